// File: rtl/imem_loader.sv
// imem_loader
// Boot-time instruction memory loader. Takes a framed byte stream
// (16-bit little-endian word count, 4*N payload bytes, XOR checksum)
// over a valid/ready handshake, packs the payload little-endian into
// 32-bit words and writes them to consecutive word addresses starting
// at 0. The processor is held in reset until a checksum-valid image
// has been fully written.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   start          one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_data        stream byte
//   in_valid       in_data is valid
//   in_ready       loader accepts a byte this cycle
//   imem_we        instruction memory write strobe, one cycle per word
//   imem_addr      word address of the write
//   imem_wdata     instruction word of the write
//   core_reset     active-high processor reset (low only in DONE)
//   busy           load in progress
//   done           image loaded and verified
//   error          load failed
//   error_code     01 = length exceeds DEPTH, 10 = checksum mismatch
//   words_written  words written during the current or last load
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [15:0]       words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          byteCnt_q, byteCnt_d;
    logic [23:0]         wordBuf_q, wordBuf_d;
    logic [7:0]          csum_q, csum_d;
    logic                imemWe_q, imemWe_d;
    logic [ADDR_W-1:0]   imemAddr_q, imemAddr_d;
    logic [31:0]         imemWdata_q, imemWdata_d;
    logic [1:0]          errCode_q, errCode_d;
    logic [15:0]         wordsWritten_q, wordsWritten_d;
    logic                inReady_q, inReady_d;
    logic                coreReset_q, coreReset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                accept;
    logic [15:0]         lenRx;

    // in_ready is registered, so it already reflects the current state.
    assign accept = in_valid && inReady_q;
    assign lenRx  = {in_data, len_q[7:0]};

    // Next-state and next-output logic. The status outputs are computed
    // from the next state so that, once registered, they line up with
    // the state they describe.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        byteCnt_d      = byteCnt_q;
        wordBuf_d      = wordBuf_q;
        csum_d         = csum_q;
        imemWe_d       = 1'b0;
        imemAddr_d     = imemAddr_q;
        imemWdata_d    = imemWdata_q;
        errCode_d      = errCode_q;
        wordsWritten_d = wordsWritten_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // A new load restarts the frame but leaves memory alone.
                if (start) begin
                    state_d        = S_LEN_LO;
                    wordsWritten_d = 16'd0;
                    errCode_d      = 2'b00;
                    csum_d         = 8'h00;
                    byteCnt_d      = 2'd0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, in_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = lenRx;
                    if ({1'b0, lenRx} > DEPTH_W) begin
                        state_d   = S_ERROR;
                        errCode_d = 2'b01;
                    end else if (lenRx == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (byteCnt_q == 2'd3) begin
                        // Fourth byte completes the word; the running
                        // word count doubles as the write address.
                        imemWe_d       = 1'b1;
                        imemAddr_d     = wordsWritten_q[ADDR_W-1:0];
                        imemWdata_d    = {in_data, wordBuf_q};
                        wordsWritten_d = wordsWritten_q + 16'd1;
                        byteCnt_d      = 2'd0;
                        if ((wordsWritten_q + 16'd1) == len_q) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        wordBuf_d[8*byteCnt_q +: 8] = in_data;
                        byteCnt_d                   = byteCnt_q + 2'd1;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_ERROR;
                        errCode_d = 2'b10;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        inReady_d   = state_d inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
        busy_d      = inReady_d;
        coreReset_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
    end

    // State and registered outputs; reset forces the safe boot values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            len_q          <= 16'd0;
            byteCnt_q      <= 2'd0;
            wordBuf_q      <= 24'd0;
            csum_q         <= 8'h00;
            imemWe_q       <= 1'b0;
            imemAddr_q     <= '0;
            imemWdata_q    <= 32'd0;
            errCode_q      <= 2'b00;
            wordsWritten_q <= 16'd0;
            inReady_q      <= 1'b0;
            coreReset_q    <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byteCnt_q      <= byteCnt_d;
            wordBuf_q      <= wordBuf_d;
            csum_q         <= csum_d;
            imemWe_q       <= imemWe_d;
            imemAddr_q     <= imemAddr_d;
            imemWdata_q    <= imemWdata_d;
            errCode_q      <= errCode_d;
            wordsWritten_q <= wordsWritten_d;
            inReady_q      <= inReady_d;
            coreReset_q    <= coreReset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign in_ready      = inReady_q;
    assign imem_we       = imemWe_q;
    assign imem_addr     = imemAddr_q;
    assign imem_wdata    = imemWdata_q;
    assign core_reset    = coreReset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign error_code    = errCode_q;
    assign words_written = wordsWritten_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Table-driven bench for imem_loader: each record holds a byte stream and
// the expected end-of-load status and memory writes. Hand-written
// sequences cover reset values, reset mid-load, start while busy and a
// word count exactly equal to DEPTH.
// Payload checksum is the XOR of the payload bytes only (header excluded).
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic [15:0] words_written;

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .core_reset    (core_reset),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .error_code    (error_code),
        .words_written (words_written)
    );

    typedef struct packed {
        logic [0:15][7:0] stream;
        logic [7:0]       nBytes;
        logic             gaps;
        logic             expDone;
        logic             expError;
        logic [1:0]       expCode;
        logic [15:0]      expWords;
        logic [2:0]       expWrites;
        logic [0:3][31:0] expData;
    } vec_t;

    localparam int NVEC = 7;

    vec_t        vecs [NVEC];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          nw    = 0;
    logic [7:0]  wAddr [64];
    logic [31:0] wData [64];

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: logs every memory write strobe in arrival order.
    always @(negedge clk) begin
        if (imem_we && nw < 64) begin
            wAddr[nw] = imem_addr;
            wData[nw] = imem_wdata;
            nw++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // Presents one byte and waits (bounded) until it is consumed.
    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        bit ok;
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL byte_accept: byte %0h not accepted, expected acceptance", b);
        end
        if (gap) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " in_ready"},   32'(in_ready),      32'd0);
        checkOutput({tag, " imem_we"},    32'(imem_we),       32'd0);
        checkOutput({tag, " imem_addr"},  32'(imem_addr),     32'd0);
        checkOutput({tag, " imem_wdata"}, imem_wdata,         32'd0);
        checkOutput({tag, " core_reset"}, 32'(core_reset),    32'd1);
        checkOutput({tag, " busy"},       32'(busy),          32'd0);
        checkOutput({tag, " done"},       32'(done),          32'd0);
        checkOutput({tag, " error"},      32'(error),         32'd0);
        checkOutput({tag, " error_code"}, 32'(error_code),    32'd0);
        checkOutput({tag, " words"},      32'(words_written), 32'd0);
    endtask

    initial begin
        int base;
        int startCyc;

        // Two-word image: payload XOR 13^05^10^00^93^05^20^00 = B0.
        vecs[0] = '{stream: 128'h0200_1305_1000_9305_2000_B000_0000_0000, nBytes: 8'd11,
                    gaps: 1'b0, expDone: 1'b1, expError: 1'b0, expCode: 2'b00,
                    expWords: 16'd2, expWrites: 3'd2,
                    expData: {32'h00100513, 32'h00200593, 32'h0, 32'h0}};
        vecs[1] = vecs[0];
        vecs[1].gaps = 1'b1;
        vecs[2] = '{stream: 128'h0200_1305_1000_9305_2000_0300_0000_0000, nBytes: 8'd11,
                    gaps: 1'b0, expDone: 1'b0, expError: 1'b1, expCode: 2'b10,
                    expWords: 16'd2, expWrites: 3'd2,
                    expData: {32'h00100513, 32'h00200593, 32'h0, 32'h0}};
        vecs[3] = '{stream: 128'h0, nBytes: 8'd3,
                    gaps: 1'b0, expDone: 1'b1, expError: 1'b0, expCode: 2'b00,
                    expWords: 16'd0, expWrites: 3'd0, expData: '0};
        vecs[4] = '{stream: 128'h0000_0100_0000_0000_0000_0000_0000_0000, nBytes: 8'd3,
                    gaps: 1'b0, expDone: 1'b0, expError: 1'b1, expCode: 2'b10,
                    expWords: 16'd0, expWrites: 3'd0, expData: '0};
        vecs[5] = '{stream: 128'h0101_0000_0000_0000_0000_0000_0000_0000, nBytes: 8'd2,
                    gaps: 1'b0, expDone: 1'b0, expError: 1'b1, expCode: 2'b01,
                    expWords: 16'd0, expWrites: 3'd0, expData: '0};
        // One word: 78^56^34^12 = 08.
        vecs[6] = '{stream: 128'h0100_7856_3412_0800_0000_0000_0000_0000, nBytes: 8'd7,
                    gaps: 1'b1, expDone: 1'b1, expError: 1'b0, expCode: 2'b00,
                    expWords: 16'd1, expWrites: 3'd1,
                    expData: {32'h12345678, 32'h0, 32'h0, 32'h0}};

        reset    = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("por");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            base = nw;
            pulseStart();
            checkOutput($sformatf("v%0d start busy", i),  32'(busy),          32'd1);
            checkOutput($sformatf("v%0d start ready", i), 32'(in_ready),      32'd1);
            checkOutput($sformatf("v%0d start done", i),  32'(done),          32'd0);
            checkOutput($sformatf("v%0d start err", i),   32'(error),         32'd0);
            checkOutput($sformatf("v%0d start code", i),  32'(error_code),    32'd0);
            checkOutput($sformatf("v%0d start words", i), 32'(words_written), 32'd0);
            checkOutput($sformatf("v%0d start crst", i),  32'(core_reset),    32'd1);
            startCyc = cyc;
            for (int j = 0; j < int'(vecs[i].nBytes); j++) begin
                applyStimulus(vecs[i].stream[j],
                              vecs[i].gaps && (j != int'(vecs[i].nBytes) - 1));
            end
            if (!vecs[i].gaps)
                checkOutput($sformatf("v%0d cycles", i), 32'(cyc - startCyc),
                            32'(vecs[i].nBytes));
            checkOutput($sformatf("v%0d done", i),  32'(done),          32'(vecs[i].expDone));
            checkOutput($sformatf("v%0d error", i), 32'(error),         32'(vecs[i].expError));
            checkOutput($sformatf("v%0d code", i),  32'(error_code),    32'(vecs[i].expCode));
            checkOutput($sformatf("v%0d words", i), 32'(words_written), 32'(vecs[i].expWords));
            checkOutput($sformatf("v%0d crst", i),  32'(core_reset),    32'(!vecs[i].expDone));
            checkOutput($sformatf("v%0d busy", i),  32'(busy),          32'd0);
            checkOutput($sformatf("v%0d ready", i), 32'(in_ready),      32'd0);
            checkOutput($sformatf("v%0d we", i),    32'(imem_we),       32'd0);
            checkOutput($sformatf("v%0d nwrites", i), 32'(nw - base), 32'(vecs[i].expWrites));
            for (int k = 0; k < int'(vecs[i].expWrites); k++) begin
                checkOutput($sformatf("v%0d waddr%0d", i, k), 32'(wAddr[base + k]), 32'(k));
                checkOutput($sformatf("v%0d wdata%0d", i, k), wData[base + k],
                            vecs[i].expData[k]);
            end
            if (vecs[i].expWrites != 3'd0) begin
                checkOutput($sformatf("v%0d hold addr", i), 32'(imem_addr),
                            32'(vecs[i].expWrites) - 32'd1);
                checkOutput($sformatf("v%0d hold data", i), imem_wdata,
                            vecs[i].expData[int'(vecs[i].expWrites) - 1]);
            end
        end

        // start while a load is in progress must be ignored.
        base = nw;
        pulseStart();
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h78, 1'b0);
        applyStimulus(8'h56, 1'b0);
        pulseStart();
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h08, 1'b0);
        checkOutput("busystart done",  32'(done),          32'd1);
        checkOutput("busystart words", 32'(words_written), 32'd1);
        checkOutput("busystart nw",    32'(nw - base),     32'd1);
        checkOutput("busystart data",  wData[base],        32'h12345678);

        // Reset mid-load after header plus six payload bytes.
        pulseStart();
        for (int j = 0; j < 8; j++) applyStimulus(vecs[0].stream[j], 1'b0);
        reset = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base = nw;
        pulseStart();
        for (int j = 0; j < 11; j++) applyStimulus(vecs[0].stream[j], 1'b0);
        checkOutput("reload done",   32'(done),          32'd1);
        checkOutput("reload crst",   32'(core_reset),    32'd0);
        checkOutput("reload words",  32'(words_written), 32'd2);
        checkOutput("reload nw",     32'(nw - base),     32'd2);
        checkOutput("reload waddr0", 32'(wAddr[base]),   32'd0);
        checkOutput("reload wdata0", wData[base],        32'h00100513);
        checkOutput("reload waddr1", 32'(wAddr[base + 1]), 32'd1);
        checkOutput("reload wdata1", wData[base + 1],    32'h00200593);

        // N equal to DEPTH is legal and enters the payload phase.
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h01, 1'b0);
        checkOutput("depth error", 32'(error),    32'd0);
        checkOutput("depth busy",  32'(busy),     32'd1);
        checkOutput("depth ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        #1;
        checkResetValues("depthreset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
